rr_sel_encoder: RTL

- Round-robin request encoder. It generates the binary select code that drives the downstream case-statement multiplexers (the select/parc/fullc side of the datapath).
- It accepts a vector of requests, arbitrates fairly among them, and presents a registered select code plus a one-hot grant.
- It holds the code until the consumer signals done, or until a watchdog expires.
- It sits directly in front of the `case(sel)` output-select logic.

---
 rtl/rr_sel_encoder_if.sv | 32 +++
 rtl/rr_sel_encoder.sv | 111 +++++++++++
 2 files changed

// File: rtl/rr_sel_encoder_if.sv
// Request/select bundle between the requesters/consumer (master) and the
// round-robin select encoder (slave).
interface rr_sel_encoder_if #(
    parameter int N = 4
) ();
    localparam int SELW = $clog2(N);

    logic [N-1:0]    req;
    logic            done;
    logic [SELW-1:0] sel;
    logic            sel_valid;
    logic [N-1:0]    grant;
    logic            timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  sel_valid,
        input  grant,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output sel_valid,
        output grant,
        output timeout
    );
endinterface : rr_sel_encoder_if

// File: rtl/rr_sel_encoder.sv
// Round-robin request encoder: grants one requester, holds a registered select
// code and one-hot grant until done or watchdog expiry, then rotates priority.
module rr_sel_encoder #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_sel_encoder_if.slave bus
);
    localparam int SELW = $clog2(N);
    // Keep the counter at least one bit wide when the watchdog is disabled.
    localparam int WCW  = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [0:0]      IDLE     = 1'b0;
    localparam logic [0:0]      BUSY     = 1'b1;
    localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);
    localparam logic [WCW-1:0]  WD_LAST  = WCW'(HOLD_MAX - 1);
    localparam logic [WCW-1:0]  WCNT_SAT = '1;
    localparam logic [N-1:0]    ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]      state_q,   state_d;
    logic [SELW-1:0] ptr_q,     ptr_d;
    logic [WCW-1:0]  wcnt_q,    wcnt_d;
    logic [SELW-1:0] sel_q,     sel_d;
    logic [N-1:0]    grant_q,   grant_d;
    logic            timeout_q, timeout_d;

    logic [SELW-1:0] win_idx;

    // Winner = lowest requesting index at or above ptr, else lowest overall.
    // Two descending passes: the later pass overrides the wrap-around pick.
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) win_idx = SELW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i] && (i >= int'(ptr_q))) win_idx = SELW'(i);
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        wcnt_d    = wcnt_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    sel_d   = win_idx;
                    grant_d = ONE_HOT0 << win_idx;
                    wcnt_d  = '0;
                    state_d = BUSY;
                end
            end

            default: begin
                if (bus.done || ((HOLD_MAX != 0) && (wcnt_q == WD_LAST))) begin
                    // Done wins over a simultaneous expiry: no timeout then.
                    timeout_d = ~bus.done;
                    grant_d   = '0;
                    ptr_d     = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                    state_d   = IDLE;
                end else if (wcnt_q != WCNT_SAT) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wcnt_q    <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wcnt_q    <= wcnt_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = (state_q == BUSY);
    assign bus.grant     = grant_q;
    assign bus.timeout   = timeout_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q));
    a_grant_iff_valid : assert property (@(posedge clk) disable iff (rst)
        ((grant_q != '0) == (state_q == BUSY)));
    a_timeout_after_busy : assert property (@(posedge clk) disable iff (rst)
        timeout_q |-> $past(state_q == BUSY));
    a_sel_in_range : assert property (@(posedge clk) disable iff (rst)
        (sel_q <= SEL_LAST) && (ptr_q <= SEL_LAST));

endmodule : rr_sel_encoder
